// File: rtl/fetch.sv
// Instruction fetch: issues word reads to a 2-cycle memory, buffers returns in a FIFO.
// Ports: clk, rst_n, redirect/redirectPc in; memAddr out, memData in; instValid/instData/instPc out, instReady in. Trace macro: FETCH_TRACE_EN.
module fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  output logic [15:0] memAddr,
  input  logic [15:0] memData,
  output logic        instValid,
  output logic [15:0] instData,
  output logic [15:0] instPc,
  input  logic        instReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = CW + 1;

  logic [15:0]   r_pc;
  logic          r_v1;
  logic [15:0]   r_pc1;
  logic          r_v2;
  logic [15:0]   r_pc2;
  logic [15:0]   r_dat [DEPTH];
  logic [15:0]   r_fpc [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic [KW-1:0] w_credit;
  logic          w_issue;
  logic          w_enq;
  logic          w_deq;

  assign memAddr = redirect ? redirectPc : r_pc;

  // Credit counts buffered plus in-flight words; same-cycle
  // dequeue is ignored so the FIFO can never overflow.
  assign w_credit = KW'(r_count) + KW'(r_v1) + KW'(r_v2);
  assign w_issue  = redirect | (w_credit < KW'(DEPTH));
  assign w_enq    = r_v2 & ~redirect;
  assign w_deq    = instValid & instReady;

  assign instValid = (r_count != '0);
  assign instData  = r_dat[r_rd];
  assign instPc    = r_fpc[r_rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_v1  <= 1'b0;
      r_pc1 <= 16'h0000;
      r_v2  <= 1'b0;
      r_pc2 <= 16'h0000;
    end else begin
      if (w_issue) begin
        r_v1  <= 1'b1;
        r_pc1 <= memAddr;
        r_pc  <= memAddr + 16'd1;
      end else begin
        r_v1  <= 1'b0;
      end
      // Redirect kills the request issued last cycle.
      r_v2  <= r_v1 & ~redirect;
      r_pc2 <= r_pc1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wr <= r_wr + AW'(1);
      if (w_deq) r_rd <= r_rd + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_dat[r_wr] <= memData;
      r_fpc[r_wr] <= r_pc2;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_enq)
        $display("#fetch[%h] -> %h", r_pc2, memData);
      if (redirect)
        $display("#fetch redirect %h", redirectPc);
    end
  end
`else
`endif

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: cycle table for startup/stall, scoreboard of the
// accepted stream, hand sequences for redirect, wrap and reset pulse.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPc = 16'h0000;
  logic [15:0] memAddr;
  logic [15:0] memData = 16'h0000;
  logic        instValid;
  logic [15:0] instData;
  logic [15:0] instPc;
  logic        instReady = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  bit wrap_mode = 1'b0;
  bit sb_en = 1'b0;
  logic [15:0] r_a = 16'h0000;
  logic [31:0] q[$];

  fetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect(redirect), .redirectPc(redirectPc),
    .memAddr(memAddr), .memData(memData),
    .instValid(instValid), .instData(instData),
    .instPc(instPc), .instReady(instReady)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memf(input logic [15:0] a, input bit wm);
    if (wm) begin
      if (a == 16'hFFFE) return 16'h1111;
      if (a == 16'hFFFF) return 16'h2222;
      if (a == 16'h0000) return 16'h3333;
    end
    return 16'hA000 + a;
  endfunction

  // Registered read port, data 2 cycles after address.
  always @(posedge clk) begin
    r_a     <= memAddr;
    memData <= memf(r_a, wrap_mode);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic sb_restart(input logic [15:0] start);
    logic [15:0] p;
    q.delete();
    for (int i = 0; i < 48; i++) begin
      p = start + 16'(i);
      q.push_back({p, memf(p, wrap_mode)});
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    #2;
    if (sb_en && rst_n && instValid && instReady && !redirect) begin
      if (q.size() == 0) begin
        chk("sb_empty", {16'h0, instPc}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("sb_pc", {16'h0, instPc}, {16'h0, e[31:16]});
        chk("sb_data", {16'h0, instData}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic cyc(input logic rdy, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    instReady  = rdy;
    redirect   = rd;
    redirectPc = rpc;
    #1;
  endtask

  task automatic chk_word(input string nm, input logic [15:0] pc, input logic [15:0] d);
    chk({nm, "_v"}, {31'h0, instValid}, 32'h1);
    chk({nm, "_pc"}, {16'h0, instPc}, {16'h0, pc});
    chk({nm, "_d"}, {16'h0, instData}, {16'h0, d});
  endtask

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [15:0] addr;
    logic [15:0] pc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // startup with decode stalled for 10 cycles, then released
    tbl[0]  = '{1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b0, 1'b0, 16'd1, 16'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'd2, 16'd0};
    tbl[3]  = '{1'b0, 1'b1, 16'd3, 16'd0};
    tbl[4]  = '{1'b0, 1'b1, 16'd4, 16'd0};
    tbl[5]  = '{1'b0, 1'b1, 16'd4, 16'd0};
    tbl[6]  = '{1'b0, 1'b1, 16'd4, 16'd0};
    tbl[7]  = '{1'b0, 1'b1, 16'd4, 16'd0};
    tbl[8]  = '{1'b0, 1'b1, 16'd4, 16'd0};
    tbl[9]  = '{1'b0, 1'b1, 16'd4, 16'd0};
    tbl[10] = '{1'b1, 1'b1, 16'd4, 16'd0};
    tbl[11] = '{1'b1, 1'b1, 16'd4, 16'd1};
    tbl[12] = '{1'b1, 1'b1, 16'd5, 16'd2};
    tbl[13] = '{1'b1, 1'b1, 16'd6, 16'd3};
    tbl[14] = '{1'b1, 1'b1, 16'd7, 16'd4};
    tbl[15] = '{1'b1, 1'b1, 16'd8, 16'd5};

    cyc(1'b1, 1'b0, 16'h0);
    chk("rst_valid", {31'h0, instValid}, 32'h0);
    chk("rst_addr", {16'h0, memAddr}, 32'h0);
    cyc(1'b0, 1'b1, 16'h1234);
    chk("rst_addr_redir", {16'h0, memAddr}, 32'h1234);
    cyc(1'b0, 1'b0, 16'h0);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst_n = 1'b1;
        sb_restart(16'h0000);
        sb_en = 1'b1;
      end
      instReady = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_addr", i), {16'h0, memAddr}, {16'h0, tbl[i].addr});
      chk($sformatf("tbl%0d_v", i), {31'h0, instValid}, {31'h0, tbl[i].vld});
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_pc", i), {16'h0, instPc}, {16'h0, tbl[i].pc});
        chk($sformatf("tbl%0d_d", i), {16'h0, instData},
            {16'h0, 16'hA000 + tbl[i].pc});
      end
    end

    // redirect with words buffered and in flight
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 16'h0040);
    wrap_mode = 1'b0;
    sb_restart(16'h0040);
    chk("r40_addr", {16'h0, memAddr}, 32'h0040);
    cyc(1'b1, 1'b0, 16'h0);
    chk("r40_t1", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("r40_t2", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk_word("r40_t3", 16'h0040, 16'hA040);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0);

    // address wrap
    cyc(1'b1, 1'b1, 16'hFFFE);
    wrap_mode = 1'b1;
    sb_restart(16'hFFFE);
    cyc(1'b1, 1'b0, 16'h0);
    chk("wrap_t1", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("wrap_t2", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk_word("wrap0", 16'hFFFE, 16'h1111);
    cyc(1'b1, 1'b0, 16'h0);
    chk_word("wrap1", 16'hFFFF, 16'h2222);
    cyc(1'b1, 1'b0, 16'h0);
    chk_word("wrap2", 16'h0000, 16'h3333);
    cyc(1'b1, 1'b0, 16'h0);

    // back-to-back redirects
    cyc(1'b1, 1'b1, 16'h0010);
    wrap_mode = 1'b0;
    sb_restart(16'h0010);
    chk("bb_addr1", {16'h0, memAddr}, 32'h0010);
    cyc(1'b1, 1'b1, 16'h0020);
    sb_restart(16'h0020);
    chk("bb_addr2", {16'h0, memAddr}, 32'h0020);
    chk("bb_t0", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("bb_t1", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("bb_t2", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk_word("bb_t3", 16'h0020, 16'hA020);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0);

    // fill the FIFO, then pulse reset for half a cycle
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 16'h0);
    chk("full_valid", {31'h0, instValid}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, instValid}, 32'h0);
    chk("arst_addr", {16'h0, memAddr}, 32'h0000);
    #3;
    rst_n = 1'b1;
    instReady = 1'b1;
    sb_restart(16'h0000);
    cyc(1'b1, 1'b0, 16'h0);
    chk("arst_t1", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk("arst_t2", {31'h0, instValid}, 32'h0);
    cyc(1'b1, 1'b0, 16'h0);
    chk_word("arst_t3", 16'h0000, 16'hA000);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16'h0);

    sb_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
